fp_add_align_pipe: RTL and testbench

Parametrised, two-stage, back-pressurable front end for the vector floating-point add/subtract path. Per lane it orders the operands by magnitude, derives the result sign, exponent and effective operation, then right-aligns the smaller significand with guard/round/sticky bits. It sits between operand fetch and the multi-cycle significand adder. It adds a valid/ready handshake, per-thread rollback squash in both stages, and configurable format and lane count.

---
 rtl/fp_add_align_pipe.sv | 195 +++++++++++++++++++
 tb/tb_fp_add_align_pipe.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_align_pipe.sv
// ============================================================================
// Module      : fp_add_align_pipe
// Description : Two-stage, back-pressurable FP add/sub front end. Stage A
//               orders each lane's operands by magnitude and derives sign,
//               exponent, effective operation and alignment shift; stage B
//               right-aligns the smaller significand with guard/round/sticky.
//               Per-thread rollback squashes matching entries in both stages.
//               Optional macro FP_ADD_FTZ_EN flushes exp==0 operands to
//               signed zero before the compare.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_add_align_pipe #(
  parameter int LANES = 16,
  parameter int EXP_W = 8,
  parameter int SIG_W = 23,
  parameter int TID_W = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*(1+EXP_W+SIG_W)-1:0] in_op1,
  input  logic [LANES*(1+EXP_W+SIG_W)-1:0] in_op2,
  input  logic                          in_subtract,
  input  logic [LANES-1:0]              in_mask,
  input  logic [TID_W-1:0]              in_thread,
  input  logic                          rollback_en,
  input  logic [TID_W-1:0]              rollback_thread,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*(SIG_W+1)-1:0]    out_sig1,
  output logic [LANES*(SIG_W+4)-1:0]    out_sig2,
  output logic [LANES*EXP_W-1:0]        out_exponent,
  output logic [LANES-1:0]              out_logical_subtract,
  output logic [LANES-1:0]              out_result_sign,
  output logic [LANES-1:0]              out_mask,
  output logic [TID_W-1:0]              out_thread
);

  localparam int FP_W = 1 + EXP_W + SIG_W;
  localparam int AL_W = SIG_W + 4;
  localparam int FS_W = SIG_W + 1;
  localparam int SH_W = $clog2(AL_W + 1);
  localparam logic [EXP_W:0]  DIFF_MAX  = (EXP_W+1)'(AL_W);
  localparam logic [SH_W-1:0] SHIFT_MAX = SH_W'(AL_W);

  logic             r_a_valid;
  logic             r_b_valid;
  logic [TID_W-1:0] r_a_thread;
  logic [TID_W-1:0] r_b_thread;
  logic [LANES-1:0] r_a_mask;
  logic [LANES-1:0] r_b_mask;

  logic w_a_squash;
  logic w_b_squash;
  logic w_b_load_ok;
  logic w_in_take;
  logic w_a_move;

  // Handshake and squash decisions shared by every lane
  always_comb begin
    w_a_squash  = rollback_en && r_a_valid && (r_a_thread == rollback_thread);
    w_b_squash  = rollback_en && r_b_valid && (r_b_thread == rollback_thread);
    w_b_load_ok = !r_b_valid || out_ready;
    in_ready    = !r_a_valid || w_b_load_ok;
    w_in_take   = in_valid && in_ready &&
                  !(rollback_en && (in_thread == rollback_thread));
    w_a_move    = r_a_valid && w_b_load_ok && !w_a_squash;
  end

  assign out_valid  = r_b_valid;
  assign out_mask   = r_b_mask;
  assign out_thread = r_b_thread;

  // Valid bits plus thread/mask sideband; squash beats both hold and advance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a_valid  <= 1'b0;
      r_b_valid  <= 1'b0;
      r_a_thread <= '0;
      r_b_thread <= '0;
      r_a_mask   <= '0;
      r_b_mask   <= '0;
    end else begin
      if (in_ready)          r_a_valid <= w_in_take;
      else if (w_a_squash)   r_a_valid <= 1'b0;
      if (w_b_load_ok)       r_b_valid <= w_a_move;
      else if (w_b_squash)   r_b_valid <= 1'b0;
      if (w_in_take) begin
        r_a_thread <= in_thread;
        r_a_mask   <= in_mask;
      end
      if (w_a_move) begin
        r_b_thread <= r_a_thread;
        r_b_mask   <= r_a_mask;
      end
    end
  end

  genvar l;
  generate
    for (l = 0; l < LANES; l = l + 1) begin : g_lane
      logic             w_s1, w_s2, w_swap;
      logic [EXP_W-1:0] w_e1, w_e2, w_e_big, w_e_small;
      logic [FS_W-1:0]  w_f1, w_f2;
      logic [EXP_W:0]   w_diff;
      logic [SH_W-1:0]  w_shift;
      logic [AL_W-1:0]  w_ext, w_shifted, w_lost_mask, w_aligned;
      logic             w_sticky;

      logic [FS_W-1:0]  r_a_big, r_a_small;
      logic [EXP_W-1:0] r_a_exp;
      logic [SH_W-1:0]  r_a_shift;
      logic             r_a_lsub, r_a_sign;

      logic [FS_W-1:0]  r_b_sig1;
      logic [AL_W-1:0]  r_b_sig2;
      logic [EXP_W-1:0] r_b_exp;
      logic             r_b_lsub, r_b_sign;

      // Stage A: unpack, order by magnitude, saturating exponent difference
      always_comb begin
        w_s1 = in_op1[l*FP_W + FP_W - 1];
        w_s2 = in_op2[l*FP_W + FP_W - 1];
        w_e1 = in_op1[l*FP_W + SIG_W +: EXP_W];
        w_e2 = in_op2[l*FP_W + SIG_W +: EXP_W];
`ifdef FP_ADD_FTZ_EN
        w_f1 = (w_e1 != '0) ? {1'b1, in_op1[l*FP_W +: SIG_W]} : '0;
        w_f2 = (w_e2 != '0) ? {1'b1, in_op2[l*FP_W +: SIG_W]} : '0;
`else
        w_f1 = {(w_e1 != '0), in_op1[l*FP_W +: SIG_W]};
        w_f2 = {(w_e2 != '0), in_op2[l*FP_W +: SIG_W]};
`endif
        w_swap    = (w_e1 < w_e2) || ((w_e1 == w_e2) && (w_f1 < w_f2));
        w_e_big   = w_swap ? w_e2 : w_e1;
        w_e_small = w_swap ? w_e1 : w_e2;
        w_diff    = {1'b0, w_e_big} - {1'b0, w_e_small};
        w_shift   = (w_diff > DIFF_MAX) ? SHIFT_MAX : SH_W'(w_diff);
      end

      // Stage B: right shift, folding every shifted-out bit into sticky
      always_comb begin
        w_ext       = {r_a_small, 3'b000};
        w_shifted   = w_ext >> r_a_shift;
        w_lost_mask = ~({AL_W{1'b1}} << r_a_shift);
        w_sticky    = |(w_ext & w_lost_mask);
        w_aligned   = {w_shifted[AL_W-1:1], w_shifted[0] | w_sticky};
      end

      // Per-lane datapath registers load only on transfer into their stage
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_a_big   <= '0;
          r_a_small <= '0;
          r_a_exp   <= '0;
          r_a_shift <= '0;
          r_a_lsub  <= 1'b0;
          r_a_sign  <= 1'b0;
          r_b_sig1  <= '0;
          r_b_sig2  <= '0;
          r_b_exp   <= '0;
          r_b_lsub  <= 1'b0;
          r_b_sign  <= 1'b0;
        end else begin
          if (w_in_take) begin
            r_a_big   <= w_swap ? w_f2 : w_f1;
            r_a_small <= w_swap ? w_f1 : w_f2;
            r_a_exp   <= w_e_big;
            r_a_shift <= w_shift;
            r_a_lsub  <= w_s1 ^ w_s2 ^ in_subtract;
            r_a_sign  <= w_swap ? (w_s2 ^ in_subtract) : w_s1;
          end
          if (w_a_move) begin
            r_b_sig1 <= r_a_big;
            r_b_sig2 <= w_aligned;
            r_b_exp  <= r_a_exp;
            r_b_lsub <= r_a_lsub;
            r_b_sign <= r_a_sign;
          end
        end
      end

      assign out_sig1[l*FS_W +: FS_W]       = r_b_sig1;
      assign out_sig2[l*AL_W +: AL_W]       = r_b_sig2;
      assign out_exponent[l*EXP_W +: EXP_W] = r_b_exp;
      assign out_logical_subtract[l]        = r_b_lsub;
      assign out_result_sign[l]             = r_b_sign;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_fp_add_align_pipe.sv
// ============================================================================
// Module      : tb_fp_add_align_pipe
// Description : Directed self-checking bench for fp_add_align_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_add_align_pipe;

  localparam int LANES = 16;
  localparam int EXP_W = 8;
  localparam int SIG_W = 23;
  localparam int TID_W = 2;
  localparam int FP_W  = 32;
  localparam int AL_W  = 27;
  localparam int FS_W  = 24;

`ifdef FP_ADD_FTZ_EN
  localparam logic [26:0] SUBN_STICKY = 27'h0;
`else
  localparam logic [26:0] SUBN_STICKY = 27'h1;
`endif

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     in_valid;
  logic                     in_ready;
  logic [LANES*FP_W-1:0]    in_op1, in_op2;
  logic                     in_subtract;
  logic [LANES-1:0]         in_mask;
  logic [TID_W-1:0]         in_thread;
  logic                     rollback_en;
  logic [TID_W-1:0]         rollback_thread;
  logic                     out_valid;
  logic                     out_ready;
  logic [LANES*FS_W-1:0]    out_sig1;
  logic [LANES*AL_W-1:0]    out_sig2;
  logic [LANES*EXP_W-1:0]   out_exponent;
  logic [LANES-1:0]         out_logical_subtract;
  logic [LANES-1:0]         out_result_sign;
  logic [LANES-1:0]         out_mask;
  logic [TID_W-1:0]         out_thread;

  fp_add_align_pipe #(.LANES(LANES), .EXP_W(EXP_W), .SIG_W(SIG_W), .TID_W(TID_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op1(in_op1), .in_op2(in_op2), .in_subtract(in_subtract),
    .in_mask(in_mask), .in_thread(in_thread),
    .rollback_en(rollback_en), .rollback_thread(rollback_thread),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sig1(out_sig1), .out_sig2(out_sig2), .out_exponent(out_exponent),
    .out_logical_subtract(out_logical_subtract), .out_result_sign(out_result_sign),
    .out_mask(out_mask), .out_thread(out_thread)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  logic [TID_W+LANES-1:0] rx[$];

  // T1 lane vectors: 1.0+0.5, shift saturation, +0 + -0, subnormal + 1.0
  logic [31:0] t1_a   [4] = '{32'h3F800000, 32'h3F800000, 32'h00000000, 32'h00000001};
  logic [31:0] t1_b   [4] = '{32'h3F000000, 32'h30800000, 32'h80000000, 32'h3F800000};
  logic [23:0] t1_s1  [4] = '{24'h800000, 24'h800000, 24'h000000, 24'h800000};
  logic [26:0] t1_s2  [4] = '{27'h2000000, 27'h0000001, 27'h0000000, SUBN_STICKY};
  logic [7:0]  t1_exp [4] = '{8'h7F, 8'h7F, 8'h00, 8'h7F};
  logic        t1_lsub[4] = '{1'b0, 1'b0, 1'b1, 1'b0};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, want);
    end
  endtask

  // Note any handshake that will complete at the coming edge, then advance
  task automatic tick();
    #1;
    if (out_valid && out_ready) rx.push_back({out_thread, out_mask});
    @(negedge clk);
  endtask

  task automatic check_lane(input string tag, input int l, input logic [23:0] s1,
                            input logic [26:0] s2, input logic [7:0] e,
                            input logic sgn, input logic lsub);
    check($sformatf("%s sig1 l%0d", tag, l), 64'(out_sig1[l*FS_W +: FS_W]), 64'(s1));
    check($sformatf("%s sig2 l%0d", tag, l), 64'(out_sig2[l*AL_W +: AL_W]), 64'(s2));
    check($sformatf("%s exp l%0d", tag, l), 64'(out_exponent[l*EXP_W +: EXP_W]), 64'(e));
    check($sformatf("%s sign l%0d", tag, l), 64'(out_result_sign[l]), 64'(sgn));
    check($sformatf("%s lsub l%0d", tag, l), 64'(out_logical_subtract[l]), 64'(lsub));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_op1 = '0; in_op2 = '0; in_subtract = 1'b0;
    in_mask = '0; in_thread = '0; rollback_en = 1'b0; rollback_thread = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst in_ready", 64'(in_ready), 64'd1);
    check("rst outputs zero", 64'(|{out_sig1, out_sig2, out_exponent, out_mask, out_thread}), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Two back-to-back transactions: T1 mixed FADD lanes, T2 FSUB swap case
    for (int l = 0; l < LANES; l++) begin
      in_op1[l*FP_W +: FP_W] = t1_a[(l < 4) ? l : 0];
      in_op2[l*FP_W +: FP_W] = t1_b[(l < 4) ? l : 0];
    end
    in_valid = 1'b1; in_subtract = 1'b0; in_thread = 2'd2; in_mask = 16'hA5A5;
    out_ready = 1'b1;
    tick();
    check("lat out_valid +1", 64'(out_valid), 64'd0);
    for (int l = 0; l < LANES; l++) begin
      in_op1[l*FP_W +: FP_W] = 32'h3F000000;
      in_op2[l*FP_W +: FP_W] = 32'h3F800000;
    end
    in_subtract = 1'b1; in_thread = 2'd1; in_mask = 16'h0F0F;
    tick();
    in_valid = 1'b0;
    check("lat out_valid +2", 64'(out_valid), 64'd1);
    check("T1 thread", 64'(out_thread), 64'd2);
    check("T1 mask", 64'(out_mask), 64'hA5A5);
    for (int l = 0; l < LANES; l++)
      check_lane("T1", l, t1_s1[(l < 4) ? l : 0], t1_s2[(l < 4) ? l : 0],
                 t1_exp[(l < 4) ? l : 0], 1'b0, t1_lsub[(l < 4) ? l : 0]);
    tick();
    check("T2 out_valid", 64'(out_valid), 64'd1);
    check("T2 thread", 64'(out_thread), 64'd1);
    check_lane("T2", 0, 24'h800000, 27'h2000000, 8'h7F, 1'b1, 1'b1);
    check_lane("T2", 15, 24'h800000, 27'h2000000, 8'h7F, 1'b1, 1'b1);
    tick();
    check("drain out_valid", 64'(out_valid), 64'd0);

    // Back-pressure: three inputs against a stalled consumer
    rx.delete();
    out_ready = 1'b0; in_valid = 1'b1; in_subtract = 1'b0; in_thread = 2'd0;
    in_mask = 16'h0001; tick();
    in_mask = 16'h0002; tick();
    check("full in_ready", 64'(in_ready), 64'd0);
    in_mask = 16'h0003;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall in_ready", 64'(in_ready), 64'd0);
      check("stall out_mask", 64'(out_mask), 64'd1);
    end
    out_ready = 1'b1;
    #1;
    check("release in_ready comb", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    check("stall count", 64'(rx.size()), 64'd3);
    for (int i = 0; i < 3; i++)
      check($sformatf("stall order %0d", i),
            64'((rx.size() > i) ? rx[i] : '1), 64'(i + 1));

    // Rollback thread 1 in A while thread 0 waits in B
    rx.delete();
    out_ready = 1'b0; in_valid = 1'b1;
    in_thread = 2'd0; in_mask = 16'h0004; tick();
    in_thread = 2'd1; in_mask = 16'h0005; tick();
    in_valid = 1'b0;
    rollback_en = 1'b1; rollback_thread = 2'd1;
    tick();
    rollback_en = 1'b0;
    check("rb B kept", 64'(out_valid), 64'd1);
    check("rb A freed", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (4) tick();
    check("rb count", 64'(rx.size()), 64'd1);
    check("rb survivor", 64'((rx.size() > 0) ? rx[0] : '1), 64'h00004);

    // Input from the squashed thread is not accepted
    rx.delete();
    rollback_en = 1'b1; rollback_thread = 2'd2;
    in_valid = 1'b1; in_thread = 2'd2; in_mask = 16'h0008;
    tick();
    rollback_en = 1'b0; in_valid = 1'b0;
    repeat (3) tick();
    check("rb input dropped", 64'(rx.size()), 64'd0);

    // Rollback of a stalled entry in B
    out_ready = 1'b0; in_valid = 1'b1; in_thread = 2'd3; in_mask = 16'h0009;
    tick();
    in_valid = 1'b0;
    tick();
    check("rbB before", 64'(out_valid), 64'd1);
    rollback_en = 1'b1; rollback_thread = 2'd3;
    tick();
    rollback_en = 1'b0;
    check("rbB out_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    repeat (2) tick();
    check("rbB none delivered", 64'(rx.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
